// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS controller.
// The stateCtrl function maps each state to its Moore control word.
package mips_ctrl_pkg;

  // JUMP keeps code 10; ADDIWB takes the next free code, 11.
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEX   = 4'd9,
    JUMP     = 4'd10,
    ADDIWB   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcWrite;
    logic       branch;
    logic       branchNe;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       memtoReg;
    logic       regDst;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSrc;
  } ctrl_t;

  function automatic ctrl_t stateCtrl(input state_t s, input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:    begin c.memRead = 1'b1; c.aluSrcB = SRCB_FOUR; end
      DECODE:   c.aluSrcB = SRCB_IMMSH;
      MEMADR:   begin c.aluSrcA = 1'b1; c.aluSrcB = SRCB_IMM; c.aluOp = ALUOP_ADD; end
      MEMREAD:  begin c.memRead = 1'b1; c.iorD = 1'b1; end
      MEMWB:    begin c.memtoReg = 1'b1; c.regWrite = 1'b1; end
      MEMWRITE: begin c.memWrite = 1'b1; c.iorD = 1'b1; end
      EXECUTE:  begin c.aluSrcA = 1'b1; c.aluSrcB = SRCB_REG; c.aluOp = ALUOP_FUNCT; end
      ALUWB:    begin c.regDst = 1'b1; c.regWrite = 1'b1; end
      BRANCH: begin
        c.aluSrcA  = 1'b1;
        c.aluOp    = ALUOP_SUB;
        c.pcSrc    = PCSRC_ALUOUT;
        c.branch   = (op == OP_BEQ);
        c.branchNe = (op == OP_BNE);
      end
      ADDIEX:   begin c.aluSrcA = 1'b1; c.aluSrcB = SRCB_IMM; end
      ADDIWB:   c.regWrite = 1'b1;
      JUMP:     begin c.pcSrc = PCSRC_JUMP; c.pcWrite = 1'b1; end
      default:  c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: opcode and memory handshake in, control word out.
interface multicycle_control_if #(parameter int STATE_W = 4);
  logic [5:0]         Op;
  logic               MemReady;
  logic               PCWrite;
  logic               Branch;
  logic               BranchNe;
  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               IRWrite;
  logic               MemtoReg;
  logic               RegDst;
  logic               RegWrite;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         ALUOp;
  logic [1:0]         PCSrc;
  logic               IllegalOp;
  logic               MemError;
  logic [STATE_W-1:0] State;

  modport master (
    input  Op, MemReady,
    output PCWrite, Branch, BranchNe, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc,
           IllegalOp, MemError, State
  );

  modport slave (
    output Op, MemReady,
    input  PCWrite, Branch, BranchNe, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc,
           IllegalOp, MemError, State
  );
endinterface

// File: rtl/multicycle_control_timer.sv
// Counts MemReady-low cycles in a memory wait state and flags the timeout cycle.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic clr,
  input  logic inc,
  input  logic MemReady,
  output logic expired
);

  localparam int CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_count <= '0;
    end else if (inc && !MemReady) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // A ready in the limit cycle wins, so the !MemReady term is part of the compare.
  assign expired = (MEM_TIMEOUT > 0) && inc && !MemReady && (r_count == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Moore FSM sequencing fetch/decode/execute/memory/writeback for a multi-cycle MIPS datapath.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter bit SUPPORT_BNE = 1'b1,
  parameter int MEM_TIMEOUT = 16,
  parameter int STATE_W     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);

  state_t r_state;
  ctrl_t  r_ctrl;
  state_t w_nextState;
  state_t w_decodeTarget;
  ctrl_t  w_ctrl;
  logic   w_opLegal;
  logic   w_inWait;
  logic   w_expired;
  logic   w_clr;
  logic   w_fetchDone;
  logic   w_stateKnown;

  always_comb begin
    w_decodeTarget = FETCH;
    w_opLegal      = 1'b1;
    case (bus.Op)
      OP_LW, OP_SW: w_decodeTarget = MEMADR;
      OP_RTYPE:     w_decodeTarget = EXECUTE;
      OP_BEQ:       w_decodeTarget = BRANCH;
      OP_BNE: begin
        if (SUPPORT_BNE) w_decodeTarget = BRANCH;
        else             w_opLegal      = 1'b0;
      end
      OP_ADDI:      w_decodeTarget = ADDIEX;
      OP_J:         w_decodeTarget = JUMP;
      default:      w_opLegal      = 1'b0;
    endcase
  end

  assign w_inWait = (r_state == FETCH) || (r_state == MEMREAD) || (r_state == MEMWRITE);

  always_comb begin
    w_nextState = FETCH;
    case (r_state)
      FETCH:    w_nextState = bus.MemReady ? DECODE : FETCH;
      DECODE:   w_nextState = w_decodeTarget;
      MEMADR:   w_nextState = (bus.Op == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  w_nextState = bus.MemReady ? MEMWB : MEMREAD;
      MEMWB:    w_nextState = FETCH;
      MEMWRITE: w_nextState = bus.MemReady ? FETCH : MEMWRITE;
      EXECUTE:  w_nextState = ALUWB;
      ALUWB:    w_nextState = FETCH;
      BRANCH:   w_nextState = FETCH;
      ADDIEX:   w_nextState = ADDIWB;
      ADDIWB:   w_nextState = FETCH;
      JUMP:     w_nextState = FETCH;
      default:  w_nextState = FETCH;
    endcase
    if (w_expired) w_nextState = FETCH;
  end

  // Any state change clears the counter; a FETCH timeout re-enters FETCH, so clear on that too.
  assign w_clr = reset || w_expired || (w_nextState != r_state);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .clr     (w_clr),
    .inc     (w_inWait),
    .MemReady(bus.MemReady),
    .expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
      r_ctrl  <= stateCtrl(FETCH, bus.Op);
    end else begin
      r_state <= w_nextState;
      r_ctrl  <= stateCtrl(w_nextState, bus.Op);
    end
  end

  // ADDIWB is the highest code in use; anything above is a corrupted state.
  assign w_stateKnown = (r_state <= ADDIWB);
  assign w_ctrl       = w_stateKnown ? r_ctrl : '0;
  assign w_fetchDone  = (r_state == FETCH) && bus.MemReady;

  assign bus.PCWrite   = w_ctrl.pcWrite | w_fetchDone;
  assign bus.IRWrite   = w_fetchDone;
  assign bus.Branch    = w_ctrl.branch;
  assign bus.BranchNe  = w_ctrl.branchNe;
  assign bus.IorD      = w_ctrl.iorD;
  assign bus.MemRead   = w_ctrl.memRead;
  assign bus.MemWrite  = w_ctrl.memWrite;
  assign bus.MemtoReg  = w_ctrl.memtoReg;
  assign bus.RegDst    = w_ctrl.regDst;
  assign bus.RegWrite  = w_ctrl.regWrite;
  assign bus.ALUSrcA   = w_ctrl.aluSrcA;
  assign bus.ALUSrcB   = w_ctrl.aluSrcB;
  assign bus.ALUOp     = w_ctrl.aluOp;
  assign bus.PCSrc     = w_ctrl.pcSrc;
  assign bus.IllegalOp = (r_state == DECODE) && !w_opLegal;
  assign bus.MemError  = w_expired;
  assign bus.State     = STATE_W'(r_state);

endmodule
